palette_ctrl: RTL

Palette access controller placed in front of the 256×16 dual-port palette RAM. It owns the RAM's single write port and single read port and shares them between three requesters:
- the video pipeline, which looks up colour indices;
- the host register interface, which does byte-wide reads and writes;
- a built-in fill sequencer, which writes one colour across an index range.

Video reads always win the read port. Host writes always win the write port. Fill writes use otherwise idle write cycles.

---
 rtl/palette_pkg.sv | 19 +
 rtl/palette_fill_seq.sv | 67 ++++++
 rtl/palette_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/palette_pkg.sv
// palette_pkg: shared widths, byte-lane enables and FSM state types for the palette controller.
package palette_pkg;
    localparam int PAL_IDX_W = 8;
    localparam int PAL_DW    = 16;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam logic [1:0] BEN_LO  = 2'b01;
    localparam logic [1:0] BEN_HI  = 2'b10;
    localparam logic [1:0] BEN_ALL = 2'b11;

    typedef enum logic [1:0] {HIDLE, HWR, HRD} host_state_e;
    typedef enum logic [1:0] {FIDLE, FRUN, FDONE} fill_state_e;

    function automatic logic [1:0] lane_ben(input logic lane);
        return (lane == LANE_HI) ? BEN_HI : BEN_LO;
    endfunction
endpackage

// File: rtl/palette_fill_seq.sv
// palette_fill_seq: walks an inclusive index range writing one colour, yielding to host writes.
module palette_fill_seq
    import palette_pkg::*;
#(
    parameter int IW = PAL_IDX_W,
    parameter int DW = PAL_DW
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          stall_i,
    input  logic          start_i,
    input  logic [IW-1:0] first_i,
    input  logic [IW-1:0] last_i,
    input  logic [DW-1:0] color_i,
    output logic          wr_req_o,
    output logic [IW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o,
    output logic          busy_o,
    output logic          done_o
);
    fill_state_e   state_q, state_d;
    logic [IW:0]   ptr_q, ptr_d;
    logic [IW-1:0] last_q, last_d;
    logic [DW-1:0] color_q, color_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FIDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            color_q <= color_d;
        end
    end

    // The pointer carries one spare bit so a range ending at the top index stops instead of wrapping.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        color_d  = color_q;
        wr_req_o = 1'b0;
        case (state_q)
            FIDLE: if (start_i) begin
                ptr_d   = {1'b0, first_i};
                last_d  = last_i;
                color_d = color_i;
                state_d = (first_i > last_i) ? FDONE : FRUN;
            end
            FRUN: if (!stall_i) begin
                wr_req_o = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                state_d  = (ptr_q == {1'b0, last_q}) ? FDONE : FRUN;
            end
            default: state_d = FIDLE;
        endcase
    end

    assign wr_addr_o = ptr_q[IW-1:0];
    assign wr_data_o = color_q;
    assign busy_o    = (state_q == FRUN);
    assign done_o    = (state_q == FDONE);
endmodule

// File: rtl/palette_ctrl.sv
// palette_ctrl: arbitrates the palette RAM ports between video lookups, host byte access and the fill sequencer.
module palette_ctrl
    import palette_pkg::*;
#(
    parameter  int ENTRIES = 256,
    parameter  int DW      = PAL_DW,
    localparam int IW      = $clog2(ENTRIES),
    localparam int BW      = DW / 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [IW:0]   host_addr_i,
    input  logic [BW-1:0] host_wdata_i,
    output logic          host_ack_o,
    output logic [BW-1:0] host_rdata_o,
    input  logic          vid_rd_en_i,
    input  logic [IW-1:0] vid_idx_i,
    output logic          vid_valid_o,
    output logic [DW-1:0] vid_rdata_o,
    input  logic          fill_start_i,
    input  logic [IW-1:0] fill_first_i,
    input  logic [IW-1:0] fill_last_i,
    input  logic [DW-1:0] fill_color_i,
    output logic          fill_busy_o,
    output logic          fill_done_o,
    output logic          pal_wr_en_o,
    output logic [1:0]    pal_ben_o,
    output logic [IW-1:0] pal_wr_addr_o,
    output logic [DW-1:0] pal_wr_data_o,
    output logic          pal_rd_en_o,
    output logic [IW-1:0] pal_rd_addr_o,
    input  logic [DW-1:0] pal_rd_data_i
);
    host_state_e   hst_q, hst_d;
    logic          lane_q, lane_d;
    logic          vid_valid_q;
    logic          wr_en_q, wr_en_d;
    logic [1:0]    ben_q, ben_d;
    logic [IW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          host_wr, host_rd;
    logic          fill_req;
    logic [IW-1:0] fill_addr;
    logic [DW-1:0] fill_data;

    assign host_wr = (hst_q == HIDLE) && host_req_i && host_we_i;
    assign host_rd = (hst_q == HIDLE) && host_req_i && !host_we_i && !vid_rd_en_i;

    palette_fill_seq #(.IW(IW), .DW(DW)) u_fill (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .stall_i   (host_wr),
        .start_i   (fill_start_i),
        .first_i   (fill_first_i),
        .last_i    (fill_last_i),
        .color_i   (fill_color_i),
        .wr_req_o  (fill_req),
        .wr_addr_o (fill_addr),
        .wr_data_o (fill_data),
        .busy_o    (fill_busy_o),
        .done_o    (fill_done_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hst_q       <= HIDLE;
            lane_q      <= LANE_LO;
            vid_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            ben_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            hst_q       <= hst_d;
            lane_q      <= lane_d;
            vid_valid_q <= vid_rd_en_i;
            wr_en_q     <= wr_en_d;
            ben_q       <= ben_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        hst_d     = (hst_q == HIDLE) ? (host_wr ? HWR : host_rd ? HRD : HIDLE) : HIDLE;
        lane_d    = (host_wr || host_rd) ? host_addr_i[0] : lane_q;
        wr_en_d   = host_wr || fill_req;
        ben_d     = host_wr ? lane_ben(host_addr_i[0]) : fill_req ? BEN_ALL : 2'b00;
        wr_addr_d = host_wr ? host_addr_i[IW:1] : fill_req ? fill_addr : '0;
        wr_data_d = host_wr ? {host_wdata_i, host_wdata_i} : fill_req ? fill_data : '0;
    end

    // Read-side outputs are combinational, so they are gated to keep every output low during reset.
    assign pal_rd_en_o   = rst_n_i && (vid_rd_en_i || host_rd);
    assign pal_rd_addr_o = !rst_n_i ? '0 : vid_rd_en_i ? vid_idx_i : host_rd ? host_addr_i[IW:1] : '0;
    assign vid_rdata_o   = rst_n_i ? pal_rd_data_i : '0;
    assign vid_valid_o   = vid_valid_q;
    assign host_ack_o    = (hst_q != HIDLE);
    assign host_rdata_o  = (hst_q != HRD) ? '0 : (lane_q == LANE_HI) ? pal_rd_data_i[DW-1:BW] : pal_rd_data_i[BW-1:0];
    assign pal_wr_en_o   = wr_en_q;
    assign pal_ben_o     = ben_q;
    assign pal_wr_addr_o = wr_addr_q;
    assign pal_wr_data_o = wr_data_q;
endmodule
